// File: rtl/updown_pkg.sv
// Shared definitions for the up/down counter direction controller.
// Direction encoding matches the counter's mode input: 0 = up, 1 = down.
package updown_pkg;

  localparam int DEF_WIDTH = 3;

  localparam logic [0:0] ST_UP   = 1'b0;
  localparam logic [0:0] ST_DOWN = 1'b1;

endpackage

// File: rtl/updown_dir_ctrl_btn_debounce.sv
// Button conditioner: two-flop synchronizer followed by a stability counter.
// The output level only follows the input after DEB_CYCLES matching samples.
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1_reg;
  logic             s2_reg;
  logic             level_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= raw;
      s2_reg <= s1_reg;
    end
  end

  // Any sample that agrees with the accepted level restarts the count.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else if (s2_reg == level_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg   <= '0;
      level_reg <= s2_reg;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/updown_dir_ctrl.sv
// Direction controller for the ripple up/down counter: manual toggle via a
// debounced button, optional ping-pong reversal at terminal count.
module updown_dir_ctrl
  import updown_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] q,
  input  logic             btn,
  input  logic             auto_en,
  output logic             m,
  output logic             tc,
  output logic             dir_chg
);

  localparam logic [WIDTH-1:0] Q_MAX = '1;

  logic [WIDTH-1:0] q_s1_reg;
  logic [WIDTH-1:0] q_s2_reg;
  logic [WIDTH-1:0] q_stable_reg;
  logic [WIDTH-1:0] q_prev_reg;
  logic [0:0]       state_reg;
  logic [0:0]       state_next;
  logic             tc_reg;
  logic             dir_chg_reg;
  logic             btn_db;
  logic             btn_db_d_reg;
  logic             tog_req;
  logic             hit_up;
  logic             hit_dn;
  logic             rev_req;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_q_sync
      always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
          q_s1_reg[gi] <= 1'b0;
          q_s2_reg[gi] <= 1'b0;
        end else begin
          q_s1_reg[gi] <= q[gi];
          q_s2_reg[gi] <= q_s1_reg[gi];
        end
      end
    end
  endgenerate

  // Only accept a value seen identically on two consecutive samples, so a
  // ripple transient that lasts one sample never reaches q_stable.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q_stable_reg <= '0;
      q_prev_reg   <= '0;
    end else begin
      if (q_s1_reg == q_s2_reg) begin
        q_stable_reg <= q_s2_reg;
      end
      q_prev_reg <= q_stable_reg;
    end
  end

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .clr   (clr),
    .raw   (btn),
    .level (btn_db)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      btn_db_d_reg <= 1'b0;
    end else begin
      btn_db_d_reg <= btn_db;
    end
  end

  assign tog_req = btn_db & ~btn_db_d_reg;

  assign hit_up = (state_reg == ST_UP) && (q_stable_reg == Q_MAX) && (q_prev_reg != Q_MAX);
  assign hit_dn = (state_reg == ST_DOWN) && (q_stable_reg == '0) && (q_prev_reg != '0);

  // A manual toggle landing on the same cycle as an auto reversal cancels it.
  assign rev_req = (auto_en & (hit_up | hit_dn)) ^ tog_req;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_UP:   if (rev_req) state_next = ST_DOWN;
      ST_DOWN: if (rev_req) state_next = ST_UP;
      default: state_next = ST_UP;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg   <= ST_UP;
      tc_reg      <= 1'b0;
      dir_chg_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tc_reg      <= hit_up | hit_dn;
      dir_chg_reg <= (state_next != state_reg);
    end
  end

  assign m       = state_reg[0];
  assign tc      = tc_reg;
  assign dir_chg = dir_chg_reg;

endmodule

// File: tb/tb_updown_dir_ctrl.sv
// Directed bench for updown_dir_ctrl with a per-cycle expectation scoreboard.
module tb_updown_dir_ctrl;

  logic       clk;
  logic       clr;
  logic [2:0] q;
  logic       btn;
  logic       auto_en;
  logic       m;
  logic       tc;
  logic       dir_chg;

  int checks;
  int errors;

  typedef struct {
    logic  m;
    logic  tc;
    logic  dc;
    string tag;
  } exp_t;

  exp_t sb[$];

  updown_dir_ctrl #(
    .WIDTH      (3),
    .DEB_CYCLES (4)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .q       (q),
    .btn     (btn),
    .auto_en (auto_en),
    .m       (m),
    .tc      (tc),
    .dir_chg (dir_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic em, input logic etc, input logic edc, input string tag);
    exp_t e;
    e.m   = em;
    e.tc  = etc;
    e.dc  = edc;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL sb_empty observed size=%0d expected >0", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks += 3;
      assert (m === e.m) else begin
        errors++;
        $error("FAIL %s.m observed=%b expected=%b", e.tag, m, e.m);
      end
      assert (tc === e.tc) else begin
        errors++;
        $error("FAIL %s.tc observed=%b expected=%b", e.tag, tc, e.tc);
      end
      assert (dir_chg === e.dc) else begin
        errors++;
        $error("FAIL %s.dir_chg observed=%b expected=%b", e.tag, dir_chg, e.dc);
      end
    end
  endtask

  // One clock edge: record what should be visible after it, then compare.
  task automatic tick(input logic em, input logic etc, input logic edc, input string tag);
    push(em, etc, edc, tag);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic quiet(input int n, input logic em, input string tag);
    for (int i = 0; i < n; i++) tick(em, 1'b0, 1'b0, tag);
  endtask

  // Drive q and hold it n cycles; hit_at = 0 means no terminal event expected.
  task automatic apply_q(input logic [2:0] v, input int n, input int hit_at,
                         input logic m_pre, input logic m_post, input logic dc);
    q = v;
    $display("q=%0d auto_en=%b hold=%0d hit_at=%0d m %b->%b", v, auto_en, n, hit_at, m_pre, m_post);
    for (int i = 1; i <= n; i++) begin
      if (hit_at == 0 || i < hit_at) tick(m_pre, 1'b0, 1'b0, "q_step");
      else if (i == hit_at)          tick(m_post, 1'b1, dc, "q_hit");
      else                           tick(m_post, 1'b0, 1'b0, "q_step");
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    clr     = 1'b0;
    q       = 3'd0;
    btn     = 1'b0;
    auto_en = 1'b0;

    // Reset held while inputs thrash.
    $display("reset hold with btn/q toggling");
    for (int i = 0; i < 6; i++) begin
      btn = ~btn;
      q   = q + 3'd3;
      tick(1'b0, 1'b0, 1'b0, "rst_hold");
    end
    btn = 1'b0;
    q   = 3'd0;
    clr = 1'b1;
    $display("reset release with q=0");
    quiet(6, 1'b0, "rst_release");

    // Ping-pong up then down.
    auto_en = 1'b1;
    for (int v = 1; v <= 6; v++) apply_q(3'(v), 8, 0, 1'b0, 1'b0, 1'b0);
    apply_q(3'd7, 8, 4, 1'b0, 1'b1, 1'b1);
    for (int v = 6; v >= 1; v--) apply_q(3'(v), 8, 0, 1'b1, 1'b1, 1'b0);
    apply_q(3'd0, 8, 4, 1'b1, 1'b0, 1'b1);

    // Auto off: tc only.
    auto_en = 1'b0;
    $display("auto_en cleared");
    quiet(2, 1'b0, "auto_off");
    for (int v = 1; v <= 6; v++) apply_q(3'(v), 8, 0, 1'b0, 1'b0, 1'b0);
    apply_q(3'd7, 8, 4, 1'b0, 1'b0, 1'b0);

    // Bouncy button: short pulses rejected, long hold toggles once.
    for (int w = 1; w <= 3; w++) begin
      $display("btn bounce pulse width=%0d", w);
      btn = 1'b1;
      quiet(w, 1'b0, "bounce_hi");
      btn = 1'b0;
      quiet(3, 1'b0, "bounce_lo");
    end
    $display("btn held 10 cycles");
    btn = 1'b1;
    quiet(6, 1'b0, "btn_hold");
    tick(1'b1, 1'b0, 1'b1, "btn_toggle");
    quiet(3, 1'b1, "btn_hold");
    $display("btn released");
    btn = 1'b0;
    quiet(12, 1'b1, "btn_release");

    // Toggle back to UP while dwelling at 7.
    $display("btn toggle back to up");
    btn = 1'b1;
    quiet(6, 1'b1, "btn_hold2");
    tick(1'b0, 1'b0, 1'b1, "btn_toggle2");
    quiet(3, 1'b0, "btn_hold2");
    btn = 1'b0;
    quiet(8, 1'b0, "btn_release2");
    apply_q(3'd6, 8, 0, 1'b0, 1'b0, 1'b0);

    // Coincident tog_req and hit_up cancel.
    auto_en = 1'b1;
    $display("coincidence: btn press then q=7 three cycles later");
    quiet(1, 1'b0, "auto_on");
    btn = 1'b1;
    quiet(3, 1'b0, "coin_pre");
    q = 3'd7;
    quiet(3, 1'b0, "coin_pre");
    tick(1'b0, 1'b1, 1'b0, "coin_hit");
    quiet(3, 1'b0, "coin_post");
    btn = 1'b0;
    quiet(8, 1'b0, "coin_release");

    // Single-cycle glitch to terminal value is filtered.
    apply_q(3'd6, 8, 0, 1'b0, 1'b0, 1'b0);
    $display("glitch q 6->7->6 for one cycle");
    q = 3'd7;
    quiet(1, 1'b0, "glitch");
    q = 3'd6;
    quiet(8, 1'b0, "glitch_after");

    // Real hit, then async reset while tc/dir_chg/m are all high.
    $display("q=7 hit then async reset mid-cycle");
    q = 3'd7;
    quiet(3, 1'b0, "pre_rst_hit");
    tick(1'b1, 1'b1, 1'b1, "pre_rst_hit");
    #3;
    clr = 1'b0;
    push(1'b0, 1'b0, 1'b0, "async_rst");
    #1;
    pop_check();
    quiet(1, 1'b0, "async_rst_hold");
    q   = 3'd0;
    clr = 1'b1;
    quiet(4, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
